rojo_io_responder: RTL and testbench

ROJO_IO_RESPONDER -- requirements
Module: rojo_io_responder

---
 rtl/rojo_io_responder.sv | 178 +++++++++++++++++
 tb/tb_rojo_io_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rojo_io_responder.sv
// rtl/rojo_io_responder.sv - port-mapped I/O responder: scratch, loopback FIFO, status, IRQ handshake.
// Optional 8-bit interval timer compiled in with ROJO_IO_TIMER_EN.
module rojo_io_responder #(
  parameter int PORT_WIDTH = 8,
  parameter int PORT_DEPTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PORT_DEPTH-1:0] port_id,
  input  logic                  write_strobe,
  input  logic [PORT_WIDTH-1:0] out_port,
  input  logic                  read_strobe,
  input  logic                  interrupt_ack,
  output logic [PORT_WIDTH-1:0] in_port,
  output logic                  interrupt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PORT_DEPTH-1:0] A_SCRATCH = PORT_DEPTH'(0);
  localparam logic [PORT_DEPTH-1:0] A_FIFO    = PORT_DEPTH'(1);
  localparam logic [PORT_DEPTH-1:0] A_STATUS  = PORT_DEPTH'(2);
  localparam logic [PORT_DEPTH-1:0] A_MASK    = PORT_DEPTH'(3);
  localparam logic [PORT_DEPTH-1:0] A_TIMER   = PORT_DEPTH'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } irq_state_t;

  logic [PORT_WIDTH-1:0] scratch;
  logic [1:0]            irq_mask;
  logic                  overflow;
  logic                  timer_flag;
  logic [PORT_WIDTH-1:0] timer_rd;

  logic [PORT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic empty;
  logic full;
  logic push_req;
  logic push_ok;
  logic pop_ok;
  logic drop;
  logic clr_ovf;
  logic pending;
  logic [7:0]            status;
  logic [PORT_WIDTH-1:0] rd_data;
  irq_state_t            irq_state;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign push_req = write_strobe & (port_id == A_FIFO);
  assign pop_ok   = read_strobe & (port_id == A_FIFO) & ~empty;
  // A push into a full FIFO still lands when the same cycle frees a slot.
  assign push_ok  = push_req & (~full | pop_ok);
  assign drop     = push_req & full & ~pop_ok;
  assign clr_ovf  = write_strobe & (port_id == A_STATUS) & out_port[2];
  assign status   = {4'b0000, timer_flag, overflow, full, empty};
  assign pending  = (irq_mask[0] & ~empty) | (irq_mask[1] & timer_flag);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scratch  <= '0;
      irq_mask <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (write_strobe && port_id == A_SCRATCH) scratch <= out_port;
      if (write_strobe && port_id == A_MASK) irq_mask <= out_port[1:0];
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Storage needs no reset: clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= out_port;
  end

`ifdef ROJO_IO_TIMER_EN
  logic [7:0] timer_reload;
  logic [7:0] timer_count;
  logic       wr_reload;
  logic       clr_tf;
  logic       tick;

  assign wr_reload = write_strobe & (port_id == A_TIMER);
  assign clr_tf    = write_strobe & (port_id == A_STATUS) & out_port[3];
  assign tick      = ~wr_reload & (timer_reload != 8'd0) & (timer_count == 8'd0);
  assign timer_rd  = PORT_WIDTH'(timer_reload);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_reload <= 8'd0;
      timer_count  <= 8'd0;
      timer_flag   <= 1'b0;
    end else begin
      if (wr_reload) begin
        timer_reload <= out_port[7:0];
        timer_count  <= out_port[7:0];
      end else if (timer_reload != 8'd0) begin
        if (timer_count == 8'd0) timer_count <= timer_reload;
        else timer_count <= timer_count - 8'd1;
      end
      // An expiry in the same cycle as a clear wins so no tick is lost.
      if (tick) timer_flag <= 1'b1;
      else if (clr_tf) timer_flag <= 1'b0;
    end
  end
`else
  assign timer_flag = 1'b0;
  assign timer_rd   = '0;
`endif

  always_comb begin
    rd_data = '0;
    case (port_id)
      A_SCRATCH: rd_data = scratch;
      A_FIFO:    rd_data = empty ? '0 : mem[rd_ptr];
      A_STATUS:  rd_data = PORT_WIDTH'(status);
      A_MASK:    rd_data = PORT_WIDTH'(irq_mask);
      A_TIMER:   rd_data = timer_rd;
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) in_port <= '0;
    else in_port <= rd_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_state <= S_IDLE;
      interrupt <= 1'b0;
    end else begin
      case (irq_state)
        S_IDLE: begin
          if (pending) begin
            irq_state <= S_REQ;
            interrupt <= 1'b1;
          end
        end
        S_REQ: begin
          if (interrupt_ack) begin
            irq_state <= S_HOLD;
            interrupt <= 1'b0;
          end
        end
        S_HOLD: begin
          irq_state <= S_IDLE;
          interrupt <= 1'b0;
        end
        default: begin
          irq_state <= S_IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rojo_io_responder.sv
// tb/tb_rojo_io_responder.sv - directed bench with a queue-based reference model of the responder.
module tb_rojo_io_responder;

  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] port_id = 8'h00;
  logic       write_strobe = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic       read_strobe = 1'b0;
  logic       interrupt_ack = 1'b0;
  logic [7:0] in_port;
  logic       interrupt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rojo_io_responder #(
    .PORT_WIDTH(8),
    .PORT_DEPTH(8),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .port_id(port_id),
    .write_strobe(write_strobe),
    .out_port(out_port),
    .read_strobe(read_strobe),
    .interrupt_ack(interrupt_ack),
    .in_port(in_port),
    .interrupt(interrupt)
  );

  logic [7:0] m_q[$];
  logic [7:0] m_scratch = 8'h00;
  logic [1:0] m_mask = 2'b00;
  bit         m_ovf = 1'b0;
  bit         m_tf = 1'b0;
  logic [7:0] m_reload = 8'h00;
  logic [7:0] m_cnt = 8'h00;
  bit         m_asserted = 1'b0;
  bit         m_holdoff = 1'b0;
  logic [7:0] exp_in = 8'h00;
  bit         exp_irq = 1'b0;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return m_scratch;
      8'h01: return (m_q.size() != 0) ? m_q[0] : 8'h00;
      8'h02: return {4'b0000, m_tf, m_ovf, m_q.size() == FD, m_q.size() == 0};
      8'h03: return {6'b000000, m_mask};
`ifdef ROJO_IO_TIMER_EN
      8'h04: return m_reload;
`endif
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    bit pend;
    bit pop_ok;
    bit full0;
    bit fifo_wr;
    if (!reset_n) begin
      m_q.delete();
      m_scratch = 8'h00;
      m_mask = 2'b00;
      m_ovf = 1'b0;
      m_tf = 1'b0;
      m_reload = 8'h00;
      m_cnt = 8'h00;
      m_asserted = 1'b0;
      m_holdoff = 1'b0;
      exp_in = 8'h00;
      exp_irq = 1'b0;
    end else begin
      exp_in = m_read(port_id);
      pend = (m_mask[0] && m_q.size() != 0) || (m_mask[1] && m_tf);
      if (m_asserted) begin
        if (interrupt_ack) begin
          m_asserted = 1'b0;
          m_holdoff = 1'b1;
        end
      end else if (m_holdoff) begin
        m_holdoff = 1'b0;
      end else if (pend) begin
        m_asserted = 1'b1;
      end
      exp_irq = m_asserted;

      full0 = (m_q.size() == FD);
      pop_ok = read_strobe && port_id == 8'h01 && m_q.size() != 0;
      fifo_wr = write_strobe && port_id == 8'h01;
      if (fifo_wr && full0 && !pop_ok) m_ovf = 1'b1;
      if (pop_ok) void'(m_q.pop_front());
      if (fifo_wr && !(full0 && !pop_ok)) m_q.push_back(out_port);
      if (write_strobe) begin
        case (port_id)
          8'h00: m_scratch = out_port;
          8'h02: begin
            if (out_port[2]) m_ovf = 1'b0;
            if (out_port[3]) m_tf = 1'b0;
          end
          8'h03: m_mask = out_port[1:0];
          default: ;
        endcase
      end
`ifdef ROJO_IO_TIMER_EN
      if (write_strobe && port_id == 8'h04) begin
        m_reload = out_port;
        m_cnt = out_port;
      end else if (m_reload != 8'h00) begin
        if (m_cnt == 8'h00) begin
          m_tf = 1'b1;
          m_cnt = m_reload;
        end else begin
          m_cnt = m_cnt - 8'h01;
        end
      end
`endif
    end
  end

  always @(negedge clk) begin
    total++;
    if (in_port !== exp_in) begin
      bad++;
      $display("FAIL model_in_port t=%0t got=%h want=%h", $time, in_port, exp_in);
    end
    total++;
    if (interrupt !== exp_irq) begin
      bad++;
      $display("FAIL model_interrupt t=%0t got=%b want=%b", $time, interrupt, exp_irq);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic op(input logic [7:0] pid, input bit ws, input logic [7:0] d, input bit rs,
                    input bit ack);
    port_id = pid;
    write_strobe = ws;
    out_port = d;
    read_strobe = rs;
    interrupt_ack = ack;
    @(negedge clk);
    write_strobe = 1'b0;
    read_strobe = 1'b0;
    interrupt_ack = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    op(a, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a);
    op(a, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pop();
    op(8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic ack();
    op(8'h02, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] pushes [5];
    logic [7:0] fills [4];
    bit seen;
    pushes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    fills = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

    repeat (2) @(negedge clk);
    chk("reset_in_port", in_port, 8'h00);
    chk("reset_interrupt", {7'b0, interrupt}, 8'h00);
    reset_n = 1'b1;

    wr(8'h00, 8'hA5);
    rd(8'h00);
    chk("scratch_readback", in_port, 8'hA5);
    wr(8'h05, 8'h3C);
    rd(8'h05);
    chk("unmapped_read", in_port, 8'h00);
    rd(8'h00);
    chk("scratch_after_unmapped", in_port, 8'hA5);

    for (int i = 0; i < 5; i++) wr(8'h01, pushes[i]);
    rd(8'h02);
    chk("status_full_ovf", in_port, 8'h06);
    for (int i = 0; i < 4; i++) begin
      pop();
      chk("fifo_pop_order", in_port, pushes[i]);
    end
    rd(8'h02);
    chk("status_empty_ovf", in_port, 8'h05);
    wr(8'h02, 8'h04);
    rd(8'h02);
    chk("status_ovf_cleared", in_port, 8'h01);

    pop();
    chk("pop_empty_data", in_port, 8'h00);
    rd(8'h02);
    chk("pop_empty_status", in_port, 8'h01);

    for (int i = 0; i < 4; i++) wr(8'h01, fills[i]);
    op(8'h01, 1'b1, 8'h99, 1'b1, 1'b0);
    chk("full_push_pop_head", in_port, 8'hA1);
    rd(8'h02);
    chk("full_push_pop_status", in_port, 8'h02);
    for (int i = 0; i < 4; i++) pop();
    chk("wrapped_last_entry", in_port, 8'h99);
    op(8'h01, 1'b1, 8'h5A, 1'b1, 1'b0);
    chk("empty_push_pop_data", in_port, 8'h00);
    rd(8'h02);
    chk("empty_push_pop_status", in_port, 8'h00);
    pop();
    chk("empty_push_pop_entry", in_port, 8'h5A);

    wr(8'h03, 8'hFF);
    rd(8'h03);
    chk("irq_mask_bits", in_port, 8'h03);
    wr(8'h03, 8'h01);
    ack();
    chk("ack_in_idle", {7'b0, interrupt}, 8'h00);

    wr(8'h01, 8'h7E);
    chk("irq_not_same_cycle", {7'b0, interrupt}, 8'h00);
    rd(8'h02);
    chk("irq_asserts", {7'b0, interrupt}, 8'h01);
    ack();
    chk("irq_acked", {7'b0, interrupt}, 8'h00);
    rd(8'h02);
    chk("irq_hold", {7'b0, interrupt}, 8'h00);
    rd(8'h02);
    chk("irq_reasserts", {7'b0, interrupt}, 8'h01);
    pop();
    chk("irq_pop_data", in_port, 8'h7E);
    chk("irq_held_after_pop", {7'b0, interrupt}, 8'h01);
    ack();
    rd(8'h02);
    rd(8'h02);
    chk("irq_stays_low", {7'b0, interrupt}, 8'h00);

`ifdef ROJO_IO_TIMER_EN
    wr(8'h03, 8'h02);
    wr(8'h04, 8'h03);
    rd(8'h04);
    chk("timer_reload_read", in_port, 8'h03);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      rd(8'h02);
      seen = interrupt;
    end
    chk("timer_irq_seen", {7'b0, seen}, 8'h01);
    ack();
    wr(8'h04, 8'h00);
    wr(8'h02, 8'h08);
    rd(8'h02);
    chk("timer_flag_cleared", in_port, 8'h01);
`else
    seen = 1'b0;
    wr(8'h04, 8'h03);
    rd(8'h04);
    chk("timer_absent_read", in_port, 8'h00);
    wr(8'h03, 8'h02);
    repeat (6) rd(8'h02);
    chk("timer_absent_status", in_port, 8'h01);
    chk("timer_absent_irq", {7'b0, interrupt}, 8'h00);
`endif

    wr(8'h03, 8'h01);
    wr(8'h01, 8'hC1);
    wr(8'h01, 8'hC2);
    rd(8'h02);
    rd(8'h01);
    chk("pre_reset_irq", {7'b0, interrupt}, 8'h01);
    chk("pre_reset_head", in_port, 8'hC1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_irq", {7'b0, interrupt}, 8'h00);
    chk("async_reset_in_port", in_port, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    rd(8'h02);
    chk("post_reset_status", in_port, 8'h01);
    rd(8'h03);
    chk("post_reset_mask", in_port, 8'h00);
    rd(8'h00);
    chk("post_reset_scratch", in_port, 8'h00);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
